fifo_frame_rd_ctrl: RTL and testbench

FIFO_FRAME_RD_CTRL -- requirements
Module: fifo_frame_rd_ctrl

---
 rtl/fifo_frame_rd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fifo_frame_rd_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_rd_ctrl.sv
// Frame reader: pulls FRAME_LEN-word frames from a FIFO into a show-ahead skid buffer feeding a ready/valid stream.
// Optional frame/stall statistics ports are added when FIFO_FRAME_RD_CTRL_STAT_EN is defined.
module fifo_frame_rd_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned LEVEL_WIDTH = 11,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned BUF_DEPTH   = 4
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   enable,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic                   busy,
`ifdef FIFO_FRAME_RD_CTRL_STAT_EN
    output logic [15:0]            frame_cnt,
    output logic [15:0]            stall_cnt,
`endif
    output logic                   frame_done
);
    localparam int unsigned ISS_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned WC_W  = $clog2(FRAME_LEN);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(RD_LATENCY + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                  state;
    logic [ISS_W-1:0]        issued;
    logic [RD_LATENCY-1:0]   vpipe;
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        buf_count;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [WC_W-1:0]         wcnt;
    logic [ENT_W-1:0]        mem [BUF_DEPTH];
    logic [ENT_W-1:0]        head;
    logic                    room;
    logic                    cap;
    logic                    pop;

    // Reads still travelling through the FIFO output latency.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(vpipe[i]);
        end
    end

    // Only issue a read when its data is guaranteed a free buffer slot on arrival.
    assign room       = (SUM_W'(buf_count) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH);
    assign fifo_rd_en = (state == BURST) && (issued < ISS_W'(FRAME_LEN)) && !fifo_rd_empty && room;
    assign cap        = vpipe[RD_LATENCY-1];
    assign head       = mem[rd_ptr];
    assign m_valid    = (buf_count != '0);
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_sop      = m_valid && head[DATA_WIDTH+1];
    assign m_eop      = m_valid && head[DATA_WIDTH];
    assign busy       = (state != IDLE);
    assign frame_done = pop && m_eop;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state  <= IDLE;
            issued <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issued <= '0;
                    if (enable && (fifo_rd_water_level >= LEVEL_WIDTH'(FRAME_LEN))) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_rd_en) begin
                        issued <= issued + ISS_W'(1);
                        if (issued == ISS_W'(FRAME_LEN - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // Buffer bookkeeping; the word counter tags sop/eop as data lands.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            wcnt      <= '0;
        end else begin
            if (cap) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                wcnt   <= (wcnt == WC_W'(FRAME_LEN - 1)) ? '0 : wcnt + WC_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({cap, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (cap) begin
            mem[wr_ptr] <= {(wcnt == '0), (wcnt == WC_W'(FRAME_LEN - 1)), fifo_rd_data};
        end
    end

`ifdef FIFO_FRAME_RD_CTRL_STAT_EN
    // frame_cnt wraps, stall_cnt saturates.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_frame_rd_ctrl.sv
// Scoreboard bench for fifo_frame_rd_ctrl with RD_LATENCY=2 and a behavioural FIFO model.
module tb_fifo_frame_rd_ctrl;
    localparam int unsigned DW  = 16;
    localparam int unsigned LW  = 11;
    localparam int unsigned FL  = 256;
    localparam int unsigned LAT = 2;
    localparam int unsigned BD  = 4;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } exp_t;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic [LW-1:0] fifo_rd_water_level = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sop;
    logic          m_eop;
    logic          busy;
    logic          frame_done;
`ifdef FIFO_FRAME_RD_CTRL_STAT_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   stall_cnt;
`endif

    exp_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            checks = 0;
    int            failures = 0;
    int            acc_cnt = 0;
    int            stall_seen = 0;
    int            fidx = 0;
    int            ready_mode = 0;
    logic [DW-1:0] seq_val = 16'h1000;
    logic          rd_en_s = 1'b0;
    logic          hold_empty = 1'b0;
    logic [DW-1:0] stage1 = '0;

    fifo_frame_rd_ctrl #(
        .DATA_WIDTH (DW),
        .LEVEL_WIDTH(LW),
        .FRAME_LEN  (FL),
        .RD_LATENCY (LAT),
        .BUF_DEPTH  (BD)
    ) dut (
        .rd_clk             (rd_clk),
        .rd_rst_n           (rd_rst_n),
        .enable             (enable),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_rd_empty      (fifo_rd_empty),
        .fifo_rd_water_level(fifo_rd_water_level),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_sop              (m_sop),
        .m_eop              (m_eop),
        .busy               (busy),
`ifdef FIFO_FRAME_RD_CTRL_STAT_EN
        .frame_cnt          (frame_cnt),
        .stall_cnt          (stall_cnt),
`endif
        .frame_done         (frame_done)
    );

    always #5 rd_clk = ~rd_clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        failures++;
        $fatal(1, "watchdog");
    end

    task automatic update_flags();
        fifo_rd_water_level = LW'(src_q.size());
        fifo_rd_empty       = hold_empty || (src_q.size() == 0);
    endtask

    // FIFO model: read enable seen mid-cycle, data appears two cycles after the request.
    initial forever begin
        @(negedge rd_clk);
        rd_en_s = fifo_rd_en;
    end

    initial forever begin
        @(posedge rd_clk);
        #1;
        fifo_rd_data = stage1;
        stage1 = '0;
        if (rd_en_s && rd_rst_n) begin
            checks++;
            if (src_q.size() == 0) begin
                failures++;
                $display("FAIL rd_on_empty got fifo_rd_en=1 required=0");
            end else begin
                stage1 = src_q.pop_front();
            end
        end
        rd_en_s = 1'b0;
        update_flags();
    end

    initial forever begin
        @(posedge rd_clk);
        #1;
        if (ready_mode == 1) m_ready = ~m_ready;
        else                 m_ready = 1'b1;
    end

    // Monitor: pops one expected word per accepted transfer.
    initial begin : monitor
        exp_t          e;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge rd_clk);
            if (rd_rst_n) begin
                if (prev_stall) begin
                    checks++;
                    if (!m_valid || (m_data !== prev_data)) begin
                        failures++;
                        $display("FAIL stall_hold got valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_word got data=%h required none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_sop, m_eop, m_data} !== e || frame_done !== e.eop) begin
                            failures++;
                            $display("FAIL word got sop=%b eop=%b data=%h done=%b required sop=%b eop=%b data=%h done=%b",
                                     m_sop, m_eop, m_data, frame_done, e.sop, e.eop, e.data, e.eop);
                        end
                    end
                    acc_cnt++;
                end else begin
                    checks++;
                    if (frame_done !== 1'b0) begin
                        failures++;
                        $display("FAIL frame_done_idle got=%b required=0", frame_done);
                    end
                end
                if (m_valid && !m_ready) stall_seen++;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, expv);
        end
    endtask

    task automatic push_words(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(seq_val);
            e.sop  = (fidx == 0);
            e.eop  = (fidx == FL - 1);
            e.data = seq_val;
            exp_q.push_back(e);
            seq_val = seq_val + DW'(1);
            fidx = (fidx + 1) % FL;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge rd_clk);
            n++;
        end
        chk("acc_reached", 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_sop"},   32'(m_sop), 32'd0);
        chk({tag, "_eop"},   32'(m_eop), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(frame_done), 32'd0);
        chk({tag, "_data"},  32'(m_data), 32'd0);
    endtask

    initial begin
        int gap;
        int n;
        int base;

        repeat (3) @(negedge rd_clk);
        chk_outputs_zero("reset");
        rd_rst_n = 1'b1;
        enable   = 1'b1;

        // One word short of a frame: must stay idle.
        push_words(FL - 1);
        repeat (6) begin
            @(negedge rd_clk);
            chk("short_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("short_busy", 32'(busy), 32'd0);
        end
        push_words(1);
        @(posedge rd_clk); #2;
        chk("busy_level_update", 32'(busy), 32'd0);
        @(posedge rd_clk); #2;
        chk("busy_burst_start", 32'(busy), 32'd1);
        wait_done(2000);
        @(negedge rd_clk);
        chk("frame1_drained", 32'(exp_q.size()), 32'd0);
        chk("frame1_idle", 32'(busy), 32'd0);

        // Alternating backpressure.
        ready_mode = 1;
        push_words(FL);
        wait_done(4000);
        @(negedge rd_clk);
        chk("toggle_drained", 32'(exp_q.size()), 32'd0);
        ready_mode = 0;

        // FIFO reports empty for 10 cycles mid-burst.
        push_words(FL);
        base = acc_cnt;
        wait_acc(base + 40, 2000);
        @(posedge rd_clk); #2;
        hold_empty    = 1'b1;
        fifo_rd_empty = 1'b1;
        repeat (10) begin
            @(negedge rd_clk);
            chk("empty_stall_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        @(posedge rd_clk); #2;
        hold_empty = 1'b0;
        update_flags();
        wait_done(2000);
        @(negedge rd_clk);
        chk("empty_stall_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames leave exactly one idle cycle.
        push_words(2 * FL);
        wait_done(2000);
        gap = 0;
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
            if (!busy) gap++;
        end while (!busy && n < 20);
        chk("b2b_idle_gap", 32'(gap), 32'd1);
        wait_done(2000);
        @(negedge rd_clk);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_FRAME_RD_CTRL_STAT_EN
        chk("stat_frame_cnt", 32'(frame_cnt), 32'd5);
        chk("stat_stall_cnt", 32'(stall_cnt), 32'(stall_seen));
`endif

        // Reset around word 100 discards the partial frame.
        push_words(300);
        base = acc_cnt;
        wait_acc(base + 100, 2000);
        @(posedge rd_clk); #3;
        rd_rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        src_q.delete();
        exp_q.delete();
        stage1       = '0;
        fifo_rd_data = '0;
        fidx         = 0;
        update_flags();
        repeat (3) @(negedge rd_clk);
        chk("midreset_held_busy", 32'(busy), 32'd0);
        rd_rst_n = 1'b1;
        push_words(FL);
        wait_done(2000);
        @(negedge rd_clk);
        chk("post_reset_drained", 32'(exp_q.size()), 32'd0);
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
